// File: rtl/mips_bus_pkg.sv
// Shared definitions for the MIPS CPU Avalon-MM initiator.
//   state_t                : bus FSM states (IDLE, FETCH, DATA, RESP)
//   DEFAULT_TIMEOUT_CYCLES : default stall limit when MIPS_BUS_TIMEOUT_EN is defined
//   FETCH_BYTEENABLE       : lane enables driven for instruction fetches
//   word_align()           : clears address bits [1:0]
package mips_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;
  localparam logic [3:0]  FETCH_BYTEENABLE       = 4'b1111;

  // Misaligned addresses are silently truncated to the containing word.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_bus_watchdog.sv
// Stall counter for the Avalon initiator, used only when MIPS_BUS_TIMEOUT_EN
// is defined.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_active       : FSM is in FETCH or DATA (counter is held at 0 otherwise,
//                    so it is always clear on entry to a transfer)
//   i_stall        : waitrequest is high this cycle
//   o_timeout      : this is stall cycle number TIMEOUT_CYCLES; the FSM
//                    abandons the transfer on this edge
module mips_bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_active,
  input  logic i_stall,
  output logic o_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_active) begin
      r_count <= '0;
    end else if (i_stall) begin
      r_count <= r_count + 1'b1;
    end
  end

  // r_count holds the number of stall cycles already seen, so the current
  // stall is the last one allowed when it equals TIMEOUT_CYCLES-1.
  assign o_timeout = i_active && i_stall && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mips_cpu_avalon_master.sv
// Avalon-MM initiator for the MIPS CPU. Arbitrates between the fetch port and
// the data port (data has fixed priority) and runs one Avalon transfer at a
// time. Optional stall timeout is enabled by defining MIPS_BUS_TIMEOUT_EN.
//
// Ports:
//   i_clk, i_reset           : clock, synchronous active-high reset
//   i_if_req/i_if_addr       : fetch request (held until o_if_ack)
//   o_if_ack/o_if_rdata      : one-cycle fetch ack, fetched word
//   i_d_req/i_d_we/i_d_addr  : data request, store flag, byte address
//   i_d_byteenable/i_d_wdata : store lanes and lane-aligned store data
//   o_d_ack/o_d_rdata        : one-cycle data ack, load word
//   o_address..o_writedata   : Avalon initiator outputs (address word-aligned)
//   i_waitrequest/i_readdata : Avalon responder stall and read data
//   o_bus_error              : pulses with the ack on a timeout abort
//   o_state                  : current FSM state (mips_bus_pkg::state_t encoding)
//
// Handshake: a requester raises req with stable fields and keeps them until
// its ack. The Avalon side completes on the first edge where read/write is
// high and waitrequest is low; until then all outputs are held unchanged.
module mips_cpu_avalon_master
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ack,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [3:0]  i_d_byteenable,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_ack,
  output logic [31:0] o_d_rdata,
  output logic [31:0] o_address,
  output logic [3:0]  o_byteenable,
  output logic        o_read,
  output logic        o_write,
  output logic [31:0] o_writedata,
  input  logic        i_waitrequest,
  input  logic [31:0] i_readdata,
  output logic        o_bus_error,
  output logic [1:0]  o_state
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_sel_data;   // 1: current transfer belongs to the data port
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        w_in_xfer;
  logic        w_timeout;

  assign w_in_xfer = (r_state == ST_FETCH) || (r_state == ST_DATA);

`ifdef MIPS_BUS_TIMEOUT_EN
  logic r_bus_error;

  mips_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_active  (w_in_xfer),
    .i_stall   (i_waitrequest),
    .o_timeout (w_timeout)
  );

  // Remembers whether the transfer that led into RESP was aborted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bus_error <= 1'b0;
    end else begin
      r_bus_error <= w_timeout;
    end
  end

  assign o_bus_error = (r_state == ST_RESP) && r_bus_error;
`else
  // Without the watchdog the stall limit has no effect.
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign w_timeout            = 1'b0;
  assign o_bus_error          = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_d_req) begin
          w_next_state = ST_DATA;
        end else if (i_if_req) begin
          w_next_state = ST_FETCH;
        end
      end
      ST_FETCH, ST_DATA: begin
        if (!i_waitrequest || w_timeout) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, request latch and read-data capture
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_sel_data <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (i_d_req) begin
            r_addr     <= word_align(i_d_addr);
            r_be       <= i_d_byteenable;
            r_wdata    <= i_d_wdata;
            r_we       <= i_d_we;
            r_sel_data <= 1'b1;
          end else if (i_if_req) begin
            r_addr     <= word_align(i_if_addr);
            r_be       <= FETCH_BYTEENABLE;
            r_we       <= 1'b0;
            r_sel_data <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (!i_waitrequest) begin
            r_if_rdata <= i_readdata;
          end
        end
        ST_DATA: begin
          if (!i_waitrequest && !r_we) begin
            r_d_rdata <= i_readdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes are decoded straight from the registered state, so they drop
  // together with the state change (completion, timeout or reset).
  assign o_read       = (r_state == ST_FETCH) || ((r_state == ST_DATA) && !r_we);
  assign o_write      = (r_state == ST_DATA) && r_we;
  assign o_address    = r_addr;
  assign o_byteenable = r_be;
  assign o_writedata  = r_wdata;
  assign o_if_ack     = (r_state == ST_RESP) && !r_sel_data;
  assign o_d_ack      = (r_state == ST_RESP) && r_sel_data;
  assign o_if_rdata   = r_if_rdata;
  assign o_d_rdata    = r_d_rdata;
  assign o_state      = r_state;

endmodule

// File: tb/tb_mips_cpu_avalon_master.sv
// Bench for mips_cpu_avalon_master: table of single transfers plus
// hand-written sequences for arbitration, reset mid-stall and stall timeout
// (timeout behaviour depends on MIPS_BUS_TIMEOUT_EN).
module tb_mips_cpu_avalon_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_byteenable;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        bus_error;
  logic [1:0]  state;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  mips_cpu_avalon_master #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_if_req       (if_req),
    .i_if_addr      (if_addr),
    .o_if_ack       (if_ack),
    .o_if_rdata     (if_rdata),
    .i_d_req        (d_req),
    .i_d_we         (d_we),
    .i_d_addr       (d_addr),
    .i_d_byteenable (d_byteenable),
    .i_d_wdata      (d_wdata),
    .o_d_ack        (d_ack),
    .o_d_rdata      (d_rdata),
    .o_address      (address),
    .o_byteenable   (byteenable),
    .o_read         (read),
    .o_write        (write),
    .o_writedata    (writedata),
    .i_waitrequest  (waitrequest),
    .i_readdata     (readdata),
    .o_bus_error    (bus_error),
    .o_state        (state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];          // read data expected at the next read ack
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Strobes low, no acks, given FSM state.
  task automatic chk_quiet(input string name, input logic [1:0] exp_state);
    chk_bit({name, "_read"}, read, 1'b0);
    chk_bit({name, "_write"}, write, 1'b0);
    chk_bit({name, "_d_ack"}, d_ack, 1'b0);
    chk_bit({name, "_if_ack"}, if_ack, 1'b0);
    chk({name, "_state"}, 32'(state), 32'(exp_state));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs[6];

  // ---------------- driver ----------------
  // Inputs are driven and outputs sampled on the falling edge.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    d_req        = v.is_data;
    if_req       = !v.is_data;
    d_we         = v.we;
    d_addr       = v.addr;
    if_addr      = v.addr;
    d_byteenable = v.be;
    d_wdata      = v.wdata;
    waitrequest  = 1'b0;
    if (!(v.is_data && v.we)) exp_q.push_back(v.rdata);
    @(negedge clk);
    for (int k = 0; k <= v.waits; k++) begin
      if (k > 0) @(negedge clk);
      chk_bit({tag, "_read"}, read, !(v.is_data && v.we));
      chk_bit({tag, "_write"}, write, v.is_data && v.we);
      chk({tag, "_address"}, address, v.exp_addr);
      chk({tag, "_byteenable"}, 32'(byteenable), 32'(v.exp_be));
      if (v.is_data && v.we) chk({tag, "_writedata"}, writedata, v.wdata);
      chk_bit({tag, "_early_ack"}, d_ack | if_ack, 1'b0);
      waitrequest = (k < v.waits);
      readdata    = (k < v.waits) ? $urandom : v.rdata;
    end
    @(negedge clk);
    waitrequest = 1'b0;
    readdata    = $urandom;
    chk_bit({tag, "_d_ack"}, d_ack, v.is_data);
    chk_bit({tag, "_if_ack"}, if_ack, !v.is_data);
    chk_bit({tag, "_resp_strobe"}, read | write, 1'b0);
    chk_bit({tag, "_bus_error"}, bus_error, 1'b0);
    if (!(v.is_data && v.we)) begin
      if (v.is_data) exp_d_rdata = exp_q.pop_front();
      else exp_if_rdata = exp_q.pop_front();
    end
    chk({tag, "_d_rdata"}, d_rdata, exp_d_rdata);
    chk({tag, "_if_rdata"}, if_rdata, exp_if_rdata);
    d_req  = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    chk_quiet({tag, "_after"}, S_IDLE);
  endtask

  // ---------------- test ----------------
  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_byteenable = '0; d_wdata = '0; waitrequest = 1'b0; readdata = '0;

    //            data  we    addr          be     wdata         rdata         w  exp_addr      exp_be
    vecs[0] = '{1'b1, 1'b0, 32'hBFC00004, 4'hF, 32'h00000000, 32'h12345678, 0, 32'hBFC00004, 4'hF};
    vecs[1] = '{1'b1, 1'b1, 32'h00001008, 4'h3, 32'hAABBCCDD, 32'h00000000, 3, 32'h00001008, 4'h3};
    vecs[2] = '{1'b0, 1'b0, 32'hBFC00006, 4'h0, 32'h00000000, 32'h3C1D0000, 0, 32'hBFC00004, 4'hF};
    vecs[3] = '{1'b0, 1'b0, 32'h00000400, 4'h0, 32'h00000000, 32'h27BDFFF0, 2, 32'h00000400, 4'hF};
    vecs[4] = '{1'b1, 1'b1, 32'h10000003, 4'h0, 32'h11223344, 32'h00000000, 1, 32'h10000000, 4'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h2000000A, 4'hC, 32'h00000000, 32'hCAFEF00D, 1, 32'h20000008, 4'hC};

    repeat (2) @(negedge clk);
    chk_quiet("reset", S_IDLE);
    chk("reset_address", address, 32'h0);
    chk("reset_writedata", writedata, 32'h0);
    chk("reset_byteenable", 32'(byteenable), 32'h0);
    chk("reset_d_rdata", d_rdata, 32'h0);
    chk("reset_if_rdata", if_rdata, 32'h0);
    chk_bit("reset_bus_error", bus_error, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Simultaneous requests: data first, fetch starts from the IDLE after RESP.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00000040; d_byteenable = 4'h5;
    if_req = 1'b1; if_addr = 32'h00000080;
    @(negedge clk);
    chk("arb_state_data", 32'(state), 32'(S_DATA));
    chk_bit("arb_read_data", read, 1'b1);
    chk("arb_addr_data", address, 32'h00000040);
    chk("arb_be_data", 32'(byteenable), 32'h5);
    readdata = 32'h0BADBEEF;
    @(negedge clk);
    chk_bit("arb_d_ack", d_ack, 1'b1);
    chk_bit("arb_if_ack_quiet", if_ack, 1'b0);
    exp_d_rdata = 32'h0BADBEEF;
    chk("arb_d_rdata", d_rdata, exp_d_rdata);
    d_req = 1'b0;
    @(negedge clk);
    chk_quiet("arb_gap", S_IDLE);
    @(negedge clk);
    chk("arb_state_fetch", 32'(state), 32'(S_FETCH));
    chk("arb_addr_fetch", address, 32'h00000080);
    chk("arb_be_fetch", 32'(byteenable), 32'hF);
    readdata = 32'h8FBF0010;
    @(negedge clk);
    chk_bit("arb_if_ack", if_ack, 1'b1);
    chk_bit("arb_d_ack_quiet", d_ack, 1'b0);
    exp_if_rdata = 32'h8FBF0010;
    chk("arb_if_rdata", if_rdata, exp_if_rdata);
    chk("arb_d_rdata_hold", d_rdata, exp_d_rdata);
    if_req = 1'b0;
    @(negedge clk);
    chk_quiet("arb_done", S_IDLE);

    // Reset during a stall: strobe drops, no ack, request discarded.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00000100; d_byteenable = 4'hF;
    waitrequest = 1'b1;
    repeat (3) @(negedge clk);
    chk_bit("rst_stall_read", read, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk_quiet("rst_abort", S_IDLE);
    chk("rst_address", address, 32'h0);
    exp_d_rdata = '0; exp_if_rdata = '0;
    chk("rst_d_rdata", d_rdata, exp_d_rdata);
    reset = 1'b0; d_req = 1'b0; waitrequest = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_quiet("rst_idle", S_IDLE);
    end

    // Stuck waitrequest.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00000300; d_byteenable = 4'hF;
    waitrequest = 1'b1; readdata = 32'hDEADDEAD;
`ifdef MIPS_BUS_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_bit("to_read", read, 1'b1);
      chk_bit("to_early_ack", d_ack, 1'b0);
      chk_bit("to_early_err", bus_error, 1'b0);
    end
    @(negedge clk);
    chk_bit("to_d_ack", d_ack, 1'b1);
    chk_bit("to_bus_error", bus_error, 1'b1);
    chk_bit("to_read_released", read, 1'b0);
    chk("to_d_rdata", d_rdata, exp_d_rdata);
    d_req = 1'b0; waitrequest = 1'b0;
    @(negedge clk);
    chk_quiet("to_after", S_IDLE);
    chk_bit("to_err_clear", bus_error, 1'b0);
`else
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk_bit("stuck_read", read, 1'b1);
      chk_bit("stuck_no_ack", d_ack, 1'b0);
      chk_bit("stuck_no_err", bus_error, 1'b0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; d_req = 1'b0; waitrequest = 1'b0;
    chk_quiet("stuck_reset", S_IDLE);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Guard against a hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
